fetch_seq_ctrl: RTL and testbench
=================================

# fetch_seq_ctrl

Fetch sequencer for the pipelined MIPS front end. It drives the PC enable and IF/ID register enable/clear of the fetch stage. It handles a variable-latency instruction memory through a request/acknowledge handshake, load-use stalls from the hazard unit, and branch redirects. Redirects that arrive while a memory access is in flight are squashed safely.

## Interface
Parameters:
- TIMEOUT, 16: max cycles waiting for Mem_Ack before abort (>=2)
- CNT_W, 16: width of the performance counter

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  asynchronous, active-low reset
- Hazard_Stall  in  1  decode-stage stall request (load-use)
- PC_Src  in  1  branch taken; redirect the PC to PC_branch
- Mem_Ack  in  1  instruction memory: Instr valid for the current PC this cycle
- Mem_Req  out  1  fetch request to instruction memory
- PC_EN  out  1  PC register load enable
- RegF_EN  out  1  IF/ID register load enable
- RegF_CLR  out  1  IF/ID register clear (bubble)
- Busy  out  1  state != IDLE
- Timeout_Err  out  1  sticky; set on TIMEOUT abort
- Stall_Cnt  out  CNT_W  stall-cycle counter (FETCH_PERF_CNT_EN only; else tied 0)

## Operation
States: IDLE, REQ, SQUASH, HOLD. Mem_Req = (state==REQ) and is a registered-state decode. PC_EN, RegF_EN and RegF_CLR are combinational from the state and the inputs.
- Reset: state=IDLE; Mem_Req, PC_EN, RegF_EN, RegF_CLR, Busy, Timeout_Err = 0; wait counter = 0; Stall_Cnt = 0.
- IDLE:
  - !Hazard_Stall -> REQ.
  - Otherwise stay in IDLE.
  - All enables 0. PC_Src is ignored.
- REQ, priority high to low:
  1. PC_Src: PC_EN=RegF_EN=RegF_CLR=1. With Mem_Ack -> stay REQ (fetched word is discarded by the clear). Without Mem_Ack -> SQUASH.
  2. Mem_Ack && !Hazard_Stall: PC_EN=RegF_EN=1; stay REQ. This gives back-to-back fetch; Mem_Req stays high for the next PC.
  3. Mem_Ack && Hazard_Stall: enables 0 -> HOLD.
  4. No ack: enables 0; wait counter increments.
- SQUASH:
  - Mem_Req=0. Waits for the stale Mem_Ack of the abandoned access, then -> REQ.
  - PC_Src in SQUASH: PC_EN=RegF_CLR=RegF_EN=1; stay SQUASH, or go to REQ if Mem_Ack is also high.
- HOLD:
  - Mem_Req=0. Instruction memory holds Instr stable while the PC is stable.
  - PC_Src: PC_EN=RegF_EN=RegF_CLR=1 -> REQ. Redirect overrides the stall.
  - !Hazard_Stall: PC_EN=RegF_EN=1 -> REQ.
  - Else stay in HOLD.
- Timeout:
  - Wait counter clears on entry to REQ/SQUASH and on every Mem_Ack.
  - When it reaches TIMEOUT-1 without an ack: Timeout_Err<=1 (sticky until RST), state -> IDLE, no enables.
- Hazard_Stall only gates the handshake at ack time. It never withdraws an issued Mem_Req.

## Timing
- Zero-wait memory (Mem_Ack high in the Mem_Req cycle): one instruction per cycle; PC_EN high every REQ cycle.
- Each N-cycle memory wait adds N cycles with PC_EN=0.
- First Mem_Req appears 1 cycle after RST deasserts, provided Hazard_Stall=0.
- Redirect latency: PC loads PC_branch on the same edge PC_Src is sampled.
  - Next Mem_Req comes 0 cycles later if the ack arrived in that cycle.
  - Otherwise it comes 1 cycle after the stale ack.
- RST asserted mid-access: immediate return to reset values. The outstanding memory access is abandoned; the memory must tolerate this.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Stall_Cnt increments each cycle with state in {REQ, SQUASH, HOLD} and PC_EN=0.
  - Saturates at all-ones; cleared only by RST.
- Undefined: no counter logic; Stall_Cnt = 0.

## Test plan
- Reset release, Hazard_Stall=0, Mem_Ack tied 1 -> Mem_Req=1 from cycle 1; PC_EN=RegF_EN=1 for 10 consecutive cycles; RegF_CLR=0.
- Mem_Ack after 3 wait cycles each fetch -> PC_EN pulses every 4th cycle; Stall_Cnt = 9 after 3 fetches (macro on).
- Ack arrives with Hazard_Stall=1 held 2 cycles -> HOLD for 2 cycles, Mem_Req=0. On stall drop: PC_EN=RegF_EN=1 for one cycle, then REQ.
- PC_Src in REQ 1 cycle after request, ack 2 cycles later -> PC_EN=RegF_CLR=1 that cycle; SQUASH with Mem_Req=0 until the stale ack; PC_EN=0 on the stale ack; REQ the next cycle.
- PC_Src and Mem_Ack in the same REQ cycle -> PC_EN=RegF_EN=RegF_CLR=1; state stays REQ; no SQUASH.
- Mem_Ack held 0 with TIMEOUT=16 -> Timeout_Err=1 after 16 REQ cycles, state IDLE; retry REQ next cycle. RST low mid-wait -> all outputs 0 immediately, Timeout_Err cleared.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: drives PC / IF-ID enables around a req/ack instruction memory.
// Optional stall-cycle performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_seq_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Hazard_Stall,
  input  logic             PC_Src,
  input  logic             Mem_Ack,
  output logic             Mem_Req,
  output logic             PC_EN,
  output logic             RegF_EN,
  output logic             RegF_CLR,
  output logic             Busy,
  output logic             Timeout_Err,
  output logic [CNT_W-1:0] Stall_Cnt
);

  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              abort;

  // An abandoned access (REQ without redirect, or SQUASH) gives up once the
  // wait counter has spent TIMEOUT cycles without an acknowledge.
  assign abort = (wait_cnt == WAIT_LAST) && !Mem_Ack &&
                 (((state == REQ) && !PC_Src) || (state == SQUASH));

  assign Mem_Req = (state == REQ);
  assign Busy    = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    PC_EN    = 1'b0;
    RegF_EN  = 1'b0;
    RegF_CLR = 1'b0;
    unique case (state)
      REQ: begin
        if (PC_Src) begin
          PC_EN    = 1'b1;
          RegF_EN  = 1'b1;
          RegF_CLR = 1'b1;
        end else if (Mem_Ack && !Hazard_Stall) begin
          PC_EN   = 1'b1;
          RegF_EN = 1'b1;
        end
      end
      SQUASH: begin
        if (PC_Src && !abort) begin
          PC_EN    = 1'b1;
          RegF_EN  = 1'b1;
          RegF_CLR = 1'b1;
        end
      end
      HOLD: begin
        if (PC_Src) begin
          PC_EN    = 1'b1;
          RegF_EN  = 1'b1;
          RegF_CLR = 1'b1;
        end else if (!Hazard_Stall) begin
          PC_EN   = 1'b1;
          RegF_EN = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (!Hazard_Stall) state <= REQ;
        end
        REQ: begin
          if (PC_Src) begin
            // With the ack in the same cycle the fetched word is cleared and
            // the redirected PC is requested immediately.
            wait_cnt <= '0;
            if (!Mem_Ack) state <= SQUASH;
          end else if (Mem_Ack) begin
            wait_cnt <= '0;
            if (Hazard_Stall) state <= HOLD;
          end else if (abort) begin
            wait_cnt    <= '0;
            Timeout_Err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SQUASH: begin
          if (Mem_Ack) begin
            wait_cnt <= '0;
            state    <= REQ;
          end else if (abort) begin
            wait_cnt    <= '0;
            Timeout_Err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          wait_cnt <= '0;
          if (PC_Src || !Hazard_Stall) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts fetch-active cycles that did not advance the PC; saturates.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Stall_Cnt <= '0;
    end else if ((state != IDLE) && !PC_EN && !(&Stall_Cnt)) begin
      Stall_Cnt <= Stall_Cnt + 1'b1;
    end
  end
`else
  assign Stall_Cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed self-checking bench for fetch_seq_ctrl (TIMEOUT=16, CNT_W=16).
module tb_fetch_seq_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK;
  logic             RST;
  logic             Hazard_Stall;
  logic             PC_Src;
  logic             Mem_Ack;
  logic             Mem_Req;
  logic             PC_EN;
  logic             RegF_EN;
  logic             RegF_CLR;
  logic             Busy;
  logic             Timeout_Err;
  logic [CNT_W-1:0] Stall_Cnt;

  int checks = 0;
  int errors = 0;

  fetch_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Hazard_Stall(Hazard_Stall),
    .PC_Src      (PC_Src),
    .Mem_Ack     (Mem_Ack),
    .Mem_Req     (Mem_Req),
    .PC_EN       (PC_EN),
    .RegF_EN     (RegF_EN),
    .RegF_CLR    (RegF_CLR),
    .Busy        (Busy),
    .Timeout_Err (Timeout_Err),
    .Stall_Cnt   (Stall_Cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic pc,
                         input logic en, input logic clr, input logic busy);
    check({tag, "_req"},  Mem_Req,  req);
    check({tag, "_pc"},   PC_EN,    pc);
    check({tag, "_en"},   RegF_EN,  en);
    check({tag, "_clr"},  RegF_CLR, clr);
    check({tag, "_busy"}, Busy,     busy);
  endtask

  task automatic drive(input logic hs, input logic src, input logic ack);
    Hazard_Stall = hs;
    PC_Src       = src;
    Mem_Ack      = ack;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #2;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_terr", Timeout_Err, 1'b0);
    check("reset_scnt", Stall_Cnt, 32'd0);

    // Zero-wait memory: back-to-back fetch from the first cycle after reset.
    mid();
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b1);
    next();
    for (int i = 0; i < 10; i++) begin
      mid();
      chk_out($sformatf("zw%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      next();
    end

    // Three-cycle wait per fetch: PC_EN every 4th cycle.
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 3; w++) begin
        drive(1'b0, 1'b0, 1'b0);
        mid();
        chk_out($sformatf("wait%0d_%0d", f, w), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        next();
      end
      drive(1'b0, 1'b0, 1'b1);
      mid();
      chk_out($sformatf("ack%0d", f), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      next();
    end
    check("scnt_3fetch", Stall_Cnt, PERF ? 32'd9 : 32'd0);

    // Ack under load-use stall: two HOLD cycles, release on stall drop.
    drive(1'b1, 1'b0, 1'b1);
    mid();
    chk_out("ack_stall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    next();
    drive(1'b1, 1'b0, 1'b0);
    mid();
    chk_out("hold1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next();
    drive(1'b0, 1'b0, 1'b0);
    mid();
    chk_out("hold2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    next();
    mid();
    chk_out("hold_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    next();

    // Redirect one cycle into a request, stale ack two cycles later.
    drive(1'b0, 1'b1, 1'b0);
    mid();
    chk_out("redir", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    next();
    drive(1'b0, 1'b0, 1'b0);
    mid();
    chk_out("squash", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next();
    drive(1'b0, 1'b0, 1'b1);
    mid();
    chk_out("stale_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    next();
    drive(1'b0, 1'b0, 1'b0);
    mid();
    chk_out("post_squash", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    next();

    // Redirect coinciding with ack: no SQUASH.
    drive(1'b0, 1'b1, 1'b1);
    mid();
    chk_out("redir_ack", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    next();
    drive(1'b0, 1'b0, 1'b1);
    mid();
    chk_out("after_redir_ack", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    next();
    check("scnt_mid", Stall_Cnt, PERF ? 32'd15 : 32'd0);

    // Memory never acknowledges: abort after TIMEOUT REQ cycles.
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      mid();
      check($sformatf("to_req%0d", i), Mem_Req, 1'b1);
      check($sformatf("to_err%0d", i), Timeout_Err, 1'b0);
      next();
    end
    mid();
    chk_out("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_err_set", Timeout_Err, 1'b1);
    check("scnt_to", Stall_Cnt, PERF ? 32'd31 : 32'd0);
    next();
    mid();
    chk_out("to_retry", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("to_err_sticky", Timeout_Err, 1'b1);
    next();

    // Reset in the middle of a wait clears everything at once.
    mid();
    RST = 1'b0;
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_terr", Timeout_Err, 1'b0);
    check("rst_mid_scnt", Stall_Cnt, 32'd0);

    // Release under hazard stall: stay IDLE until the stall drops.
    drive(1'b1, 1'b0, 1'b0);
    next();
    RST = 1'b1;
    next();
    mid();
    chk_out("idle_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    next();
    mid();
    chk_out("idle_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
